// File: rtl/io_timer_core.sv
// Memory-mapped timer on IO slot #1: 64-bit time counter, prescaler,
// compare/period event with sticky MATCH flag and level interrupt.
module io_timer_core #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_bus_rd_en,
    input  logic                  io_bus_wr_en,
    input  logic                  io_bus_cs,
    input  logic [31:0]           io_bus_address,
    input  logic [31:0]           io_bus_wr_data,
    output logic [31:0]           io_bus_rd_data,
    output logic                  timer_irq
);

    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_PRESCALE = 3'd1,
        OFF_CNT_LO   = 3'd2,
        OFF_CNT_HI   = 3'd3,
        OFF_CMP      = 3'd4,
        OFF_STATUS   = 3'd5
    } reg_off_e;

    logic                  en_q;
    logic                  irq_en_q;
    logic                  auto_reload_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] pre_cnt_q;
    logic [63:0]           time_q;
    logic [31:0]           evt_q;
    logic [31:0]           cmp_q;
    logic                  match_q;
    logic [31:0]           shadow_hi_q;

    logic [2:0]  off;
    logic        wr_fire;
    logic        rd_fire;
    logic        ctrl_wr;
    logic        clr;
    logic        tick;
    logic        tick_eff;
    logic        evt_hit;
    logic [31:0] rd_mux;

    assign off      = io_bus_address[4:2];
    assign wr_fire  = io_bus_cs && io_bus_wr_en;
    assign rd_fire  = io_bus_cs && io_bus_rd_en;
    assign ctrl_wr  = wr_fire && (off == OFF_CTRL);
    assign clr      = ctrl_wr && io_bus_wr_data[3];
    assign tick     = en_q && (pre_cnt_q == prescale_q);
    // A CLR write swallows a coincident tick completely: no count, no match.
    assign tick_eff = tick && !clr;
    assign evt_hit  = (evt_q == cmp_q);

    always_comb begin
        rd_mux = 32'd0;
        case (off)
            OFF_CTRL:     rd_mux = {29'd0, auto_reload_q, irq_en_q, en_q};
            OFF_PRESCALE: rd_mux = 32'(prescale_q);
            OFF_CNT_LO:   rd_mux = time_q[31:0];
            OFF_CNT_HI:   rd_mux = shadow_hi_q;
            OFF_CMP:      rd_mux = cmp_q;
            OFF_STATUS:   rd_mux = {31'd0, match_q};
            default:      rd_mux = 32'd0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; this is what makes a same-cycle read return pre-write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q           <= 1'b0;
            irq_en_q       <= 1'b0;
            auto_reload_q  <= 1'b0;
            prescale_q     <= '0;
            pre_cnt_q      <= '0;
            time_q         <= 64'd0;
            evt_q          <= 32'd0;
            cmp_q          <= 32'hFFFF_FFFF;
            match_q        <= 1'b0;
            shadow_hi_q    <= 32'd0;
            io_bus_rd_data <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                en_q          <= io_bus_wr_data[0];
                irq_en_q      <= io_bus_wr_data[1];
                auto_reload_q <= io_bus_wr_data[2];
            end else if (tick_eff && evt_hit && !auto_reload_q) begin
                en_q <= 1'b0;
            end

            if (wr_fire && off == OFF_PRESCALE)
                prescale_q <= io_bus_wr_data[PRESCALE_W-1:0];
            if (wr_fire && off == OFF_CMP)
                cmp_q <= io_bus_wr_data;

            if (clr)
                pre_cnt_q <= '0;
            else if (en_q)
                pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;

            if (clr)
                time_q <= 64'd0;
            else if (tick_eff)
                time_q <= time_q + 64'd1;

            if (clr)
                evt_q <= 32'd0;
            else if (tick_eff)
                evt_q <= evt_hit ? 32'd0 : evt_q + 32'd1;

            // A match set outranks a same-cycle software clear.
            if (tick_eff && evt_hit)
                match_q <= 1'b1;
            else if (wr_fire && off == OFF_STATUS && io_bus_wr_data[0])
                match_q <= 1'b0;

            if (rd_fire) begin
                io_bus_rd_data <= rd_mux;
                if (off == OFF_CNT_LO)
                    shadow_hi_q <= time_q[63:32];
            end
        end
    end

    assign timer_irq = match_q && irq_en_q;

endmodule

// File: tb/tb_io_timer_core.sv
// Scoreboarded directed bench for io_timer_core: reads push expected data,
// a monitor compares io_bus_rd_data one cycle after each accepted read.
module tb_io_timer_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_bus_rd_en;
    logic        io_bus_wr_en;
    logic        io_bus_cs;
    logic [31:0] io_bus_address;
    logic [31:0] io_bus_wr_data;
    logic [31:0] io_bus_rd_data;
    logic        timer_irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_fire_d = 1'b0;

    io_timer_core #(.PRESCALE_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .io_bus_rd_en   (io_bus_rd_en),
        .io_bus_wr_en   (io_bus_wr_en),
        .io_bus_cs      (io_bus_cs),
        .io_bus_address (io_bus_address),
        .io_bus_wr_data (io_bus_wr_data),
        .io_bus_rd_data (io_bus_rd_data),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One bus cycle: drive at negedge, take effect at the next posedge, then release.
    task automatic op(input logic rd, input logic wr, input logic cs,
                      input logic [2:0] off, input logic [31:0] data);
        @(negedge clk);
        io_bus_rd_en   = rd;
        io_bus_wr_en   = wr;
        io_bus_cs      = cs;
        io_bus_address = {27'd0, off, 2'b00};
        io_bus_wr_data = data;
        @(posedge clk);
        #1;
        io_bus_rd_en   = 1'b0;
        io_bus_wr_en   = 1'b0;
        io_bus_cs      = 1'b0;
        io_bus_wr_data = 32'd0;
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [31:0] data);
        op(1'b0, 1'b1, 1'b1, off, data);
    endtask

    task automatic rd_reg(input logic [2:0] off, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        op(1'b1, 1'b0, 1'b1, off, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: the DUT presents read data on the edge after an accepted read.
    always @(posedge clk) rd_fire_d <= io_bus_cs && io_bus_rd_en && !rst;

    always @(negedge clk) begin
        if (rd_fire_d) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_read: got 0x%08h expected no read", io_bus_rd_data);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, io_bus_rd_data, e);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        io_bus_rd_en   = 1'b0;
        io_bus_wr_en   = 1'b0;
        io_bus_cs      = 1'b0;
        io_bus_address = 32'd0;
        io_bus_wr_data = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        check("irq_reset", {31'd0, timer_irq}, 32'd0);
        for (int i = 0; i < 8; i++)
            rd_reg(3'(i), (i == 4) ? 32'hFFFF_FFFF : 32'd0, $sformatf("reset_rd_off%0d", i));

        // Prescale 3, period 5 ticks, auto-reload with IRQ
        wr_reg(3'd1, 32'd3);
        wr_reg(3'd4, 32'd4);
        wr_reg(3'd0, 32'h7);                       // EN set at edge E0
        repeat (19) @(posedge clk);
        #1 check("irq_before_first_match", {31'd0, timer_irq}, 32'd0);
        @(posedge clk);
        #1 check("irq_first_match_e20", {31'd0, timer_irq}, 32'd1);
        wr_reg(3'd5, 32'd1);                       // E21
        check("irq_cleared", {31'd0, timer_irq}, 32'd0);
        repeat (18) @(posedge clk);
        #1 check("irq_before_second_match", {31'd0, timer_irq}, 32'd0);
        @(posedge clk);
        #1 check("irq_second_match_e40", {31'd0, timer_irq}, 32'd1);
        wr_reg(3'd5, 32'd1);                       // E41
        repeat (18) @(posedge clk);                // now at E59
        wr_reg(3'd5, 32'd1);                       // E60 coincides with a match
        check("irq_match_beats_clear", {31'd0, timer_irq}, 32'd1);
        rd_reg(3'd5, 32'd1, "status_match_beats_clear");   // E61
        repeat (2) @(posedge clk);                 // now at E63
        wr_reg(3'd0, 32'hF);                       // E64: CLR with a tick
        rd_reg(3'd2, 32'd0, "clr_beats_tick_time");
        rd_reg(3'd0, 32'h7, "ctrl_after_clr");
        wr_reg(3'd0, 32'h0);

        // One-shot
        do_reset();
        wr_reg(3'd4, 32'd2);
        wr_reg(3'd0, 32'h1);                       // E0
        repeat (3) @(posedge clk);                 // ticks E1..E3, match at E3
        rd_reg(3'd0, 32'h0, "oneshot_ctrl_en_cleared");
        rd_reg(3'd5, 32'd1, "oneshot_match");
        rd_reg(3'd2, 32'd3, "oneshot_time_frozen");
        check("oneshot_irq_disabled", {31'd0, timer_irq}, 32'd0);

        // Chip-select gating and unmapped offsets
        op(1'b0, 1'b1, 1'b0, 3'd4, 32'h1234);
        op(1'b1, 1'b0, 1'b0, 3'd1, 32'd0);
        check("rd_data_holds_without_cs", io_bus_rd_data, 32'd3);
        rd_reg(3'd4, 32'd2, "cmp_unchanged_without_cs");
        wr_reg(3'd6, 32'hFFFF_FFFF);
        rd_reg(3'd6, 32'd0, "unmapped_off6");

        // Coherent 64-bit read across the low-word wrap
        @(negedge clk);
        force dut.time_q = 64'h0000_0000_FFFF_FFFE;
        @(negedge clk);
        release dut.time_q;
        wr_reg(3'd0, 32'h1);                       // E0
        rd_reg(3'd2, 32'hFFFF_FFFE, "cnt_lo_snapshot"); // E1
        repeat (3) @(posedge clk);
        rd_reg(3'd3, 32'd0, "cnt_hi_coherent");
        rd_reg(3'd2, 32'd1, "cnt_lo_after_wrap");
        rd_reg(3'd3, 32'd1, "cnt_hi_after_wrap");

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
